// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - RV32I fetch sequencer: PC ownership, imem handshake, decode handoff
// Redirects and misaligned-target traps take priority over memory and decode handshakes.
module pc_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR = 32'h0000_0100
) (
  input  logic        mp_clk_in,
  input  logic        mp_rst_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic [31:0] pc_out,
  output logic        trap_out,
  output logic [31:0] trap_pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAP} state_t;

  state_t state;

  assign imem_req_out  = (state == REQ);
  assign imem_addr_out = pc_out;
  assign trap_out      = (state == TRAP);

  always_ff @(posedge mp_clk_in or posedge mp_rst_in) begin
    if (mp_rst_in) begin
      state           <= IDLE;
      pc_out          <= BOOT_ADDR;
      instr_valid_out <= 1'b0;
      instr_out       <= 32'h0;
      instr_pc_out    <= 32'h0;
      trap_pc_out     <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ, HOLD: begin
          if (branch_taken_in) begin
            // A redirect discards both in-flight data and any held instruction.
            instr_valid_out <= 1'b0;
            if (branch_target_in[1:0] == 2'b00) begin
              pc_out <= branch_target_in;
              state  <= REQ;
            end else begin
              trap_pc_out <= branch_target_in;
              state       <= TRAP;
            end
          end else if (state == REQ) begin
            if (imem_ready_in) begin
              instr_out       <= imem_data_in;
              instr_pc_out    <= pc_out;
              instr_valid_out <= 1'b1;
              pc_out          <= pc_out + 32'd4;
              state           <= HOLD;
            end
          end else if (!stall_in) begin
            instr_valid_out <= 1'b0;
            state           <= REQ;
          end
        end
        TRAP: begin
          pc_out <= TRAP_ADDR;
          state  <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - randomized scoreboard bench for pc_fetch_ctrl
// Driver steps a transaction-level model and queues expectations; monitor pops at negedge.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] TRAPV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] tgt;
  logic        stl;
  logic        rdy;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic [31:0] pc_out;
  logic        trap_out;
  logic [31:0] trap_pc_out;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data_in = mem_word(imem_addr_out);

  pc_fetch_ctrl #(.BOOT_ADDR(BOOT), .TRAP_ADDR(TRAPV)) dut (
    .mp_clk_in(clk), .mp_rst_in(rst),
    .branch_taken_in(br), .branch_target_in(tgt), .stall_in(stl),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ready_in(rdy), .imem_data_in(imem_data_in),
    .instr_valid_out(instr_valid_out), .instr_out(instr_out), .instr_pc_out(instr_pc_out),
    .pc_out(pc_out), .trap_out(trap_out), .trap_pc_out(trap_pc_out)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic        trap;
    logic [31:0] trap_pc;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [63:0] ins_q[$];
  logic [31:0] trap_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic        prev_v = 1'b0;

  // Model: booting / trapping flags plus "holding an instruction" flag; fetching otherwise.
  bit          m_boot, m_trapping, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc, m_trap_pc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_trapping = 1'b0; m_valid = 1'b0;
    m_pc = BOOT; m_instr = 32'h0; m_ipc = 32'h0; m_trap_pc = 32'h0;
  endtask

  task automatic model_step(input logic b, input logic [31:0] t, input logic r, input logic s);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trapping) begin
      m_trapping = 1'b0;
      m_pc = TRAPV;
    end else if (b) begin
      m_valid = 1'b0;
      if (t % 4 == 0) m_pc = t;
      else begin
        m_trap_pc = t;
        m_trapping = 1'b1;
        trap_q.push_back(t);
      end
    end else if (!m_valid) begin
      if (r) begin
        m_ipc = m_pc;
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
        ins_q.push_back({m_ipc, m_instr});
      end
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic cyc_t model_out();
    cyc_t c;
    c.req = !m_boot && !m_trapping && !m_valid;
    c.addr = m_pc;
    c.pc = m_pc;
    c.valid = m_valid;
    c.trap = m_trapping;
    c.trap_pc = m_trap_pc;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(br, tgt, rdy, stl);
    cyc_q.push_back(model_out());
  endtask

  task automatic randomize_inputs();
    int k;
    rdy = ($urandom % 3) != 0;
    stl = ($urandom % 3) == 0;
    br = ($urandom % 8) == 0;
    k = int'($urandom % 4);
    case (k)
      0: tgt = {30'($urandom_range(0, 1023)), 2'b00};
      1: tgt = {30'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      2: tgt = 32'hFFFF_FFFC;
      default: tgt = {30'($urandom), 2'b00};
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_t e;
      cyc_t a;
      a = '{req: imem_req_out, addr: imem_addr_out, pc: pc_out, valid: instr_valid_out,
            trap: trap_out, trap_pc: trap_pc_out};
      if (cyc_q.size() == 0) check("cyc_q_empty", 128'(1), 128'(0));
      else begin
        e = cyc_q.pop_front();
        check("cycle", 128'(a), 128'(e));
      end
      if (instr_valid_out && !prev_v) begin
        if (ins_q.size() == 0) check("unexpected_instr", 128'({instr_pc_out, instr_out}), 128'(0));
        else check("instr", 128'({instr_pc_out, instr_out}), 128'(ins_q.pop_front()));
      end
      if (trap_out) begin
        if (trap_q.size() == 0) check("unexpected_trap", 128'(trap_pc_out), 128'(0));
        else check("trap_pc", 128'(trap_pc_out), 128'(trap_q.pop_front()));
      end
    end
    prev_v <= instr_valid_out;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 128'(imem_req_out), 128'(0));
    check({tag, "_addr"}, 128'(imem_addr_out), 128'(BOOT));
    check({tag, "_pc"}, 128'(pc_out), 128'(BOOT));
    check({tag, "_valid"}, 128'(instr_valid_out), 128'(0));
    check({tag, "_instr"}, 128'({instr_out, instr_pc_out}), 128'(0));
    check({tag, "_trap"}, 128'({trap_out, trap_pc_out}), 128'(0));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prev_v = 1'b0;
    chk_en = 1'b1;
    cyc_q.push_back(model_out());
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; tgt = 32'h0; rdy = 1'b1; stl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("boot_rst");
    release_reset();
    // Boot run: memory always ready, decode never stalls.
    repeat (12) tick();
    // Memory wait then decode stall.
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1; stl = 1'b1;
    repeat (6) tick();
    stl = 1'b0;
    repeat (4) tick();
    // Misaligned and wrap redirects.
    br = 1'b1; tgt = 32'h0000_0202;
    tick();
    br = 1'b0;
    repeat (4) tick();
    br = 1'b1; tgt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
    end
    // Reach a held instruction, then reset asynchronously mid-cycle.
    br = 1'b0; rdy = 1'b1; stl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid && !m_trapping) break;
    end
    @(negedge clk);
    check("hold_before_reset", 128'(instr_valid_out), 128'(1));
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    cyc_q.delete();
    ins_q.delete();
    trap_q.delete();
    release_reset();
    stl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      tick();
    end
    @(negedge clk);
    #1;
    check("ins_q_drained", 128'(ins_q.size() > 1), 128'(0));
    check("trap_q_drained", 128'(trap_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter of the RV32I core and decides its next value: boot, sequential +4, branch/jump redirect, or trap vector. It issues single-beat instruction-memory requests and handles the memory ready handshake. It presents the fetched instruction to decode with a valid/stall handshake. It sits between the PC register path and the instruction memory, ahead of decode.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset.
TRAP_ADDR, 32'h0000_0100, PC value loaded on a misaligned-target trap.

Ports:
mp_clk_in  input  1  core clock, rising-edge active
mp_rst_in  input  1  reset, asynchronous, active-high
branch_taken_in  input  1  redirect request from execute
branch_target_in  input  32  redirect target address
stall_in  input  1  decode cannot accept the presented instruction
imem_req_out  output  1  instruction-memory request
imem_addr_out  output  32  instruction-memory address
imem_ready_in  input  1  memory returns data this cycle
imem_data_in  input  32  returned instruction word
instr_valid_out  output  1  instr_out/instr_pc_out are valid
instr_out  output  32  fetched instruction
instr_pc_out  output  32  address of instr_out
pc_out  output  32  current fetch PC
trap_out  output  1  one-cycle misaligned-fetch trap pulse
trap_pc_out  output  32  offending target, held until the next trap

Behaviour:
- Reset (asynchronous, while mp_rst_in=1): pc_out=BOOT_ADDR, state=IDLE. imem_req_out=0, imem_addr_out=BOOT_ADDR. instr_valid_out=0, instr_out=0, instr_pc_out=0. trap_out=0, trap_pc_out=0.
- States: IDLE, REQ, HOLD, TRAP. All transitions occur on the rising edge of mp_clk_in.
- IDLE:
  - Entered only from reset.
  - Goes to REQ on the first clock edge after reset is released (one-cycle boot latency).
- REQ:
  - imem_req_out=1 and imem_addr_out=pc_out, both combinational from state.
  - While imem_ready_in=0: wait with no state change.
  - When imem_ready_in=1: latch instr_out=imem_data_in and instr_pc_out=pc_out, set instr_valid_out=1, pc_out<=pc_out+4 (32-bit wrap, no carry out), go to HOLD.
- HOLD:
  - imem_req_out=0; instr_valid_out stays 1 with instr_out and instr_pc_out stable.
  - If stall_in=1: remain in HOLD.
  - If stall_in=0: the instruction is consumed; instr_valid_out<=0 and go to REQ. There is always at least one bubble cycle between consecutive instructions.
- Redirect:
  - branch_taken_in=1 in REQ or HOLD overrides all other conditions in that cycle, including imem_ready_in and stall_in.
  - target[1:0]==0: pc_out<=branch_target_in, instr_valid_out<=0, any returned data is dropped, go to REQ.
  - target[1:0]!=0: trap_pc_out<=branch_target_in, instr_valid_out<=0, go to TRAP.
  - branch_taken_in is ignored in IDLE and TRAP.
- TRAP:
  - Lasts exactly one cycle: trap_out=1, imem_req_out=0, pc_out<=TRAP_ADDR, then go to REQ.
- Memory contract:
  - Only one request is outstanding at a time.
  - imem_addr_out may change while imem_req_out=1 only because of a redirect; memory must honour the address present in the cycle that imem_ready_in is asserted.
- Reset asserted mid-operation (any state, including an in-flight request or a held instruction): immediate return to reset values; nothing is retained.
- pc_out at 32'hFFFF_FFFC plus 4 wraps to 32'h0000_0000 with no trap.

Test Plan:
- Boot: hold mp_rst_in for 2 cycles then release, imem_ready_in tied to 1, stall_in=0 -> first imem_req_out one cycle after release at addr 0x0. Instructions then present at PCs 0x0, 0x4, 0x8, each with instr_valid_out high for 1 cycle.
- Memory wait and stall: imem_ready_in low for 3 cycles at PC 0x8 -> imem_req_out held with addr 0x8. Then stall_in=1 for 4 cycles -> instr_out/instr_pc_out=0x8 stable and valid for 5 cycles, then the next request is at 0xC.
- Aligned redirect: branch_taken_in=1, target 0x200, in the same cycle as imem_ready_in=1 at PC 0x10 -> the data is dropped, no valid issued, next request at 0x200, next instr_pc_out=0x200.
- Misaligned redirect: target 0x202 -> trap_out high for exactly 1 cycle, trap_pc_out=0x202, next request at 0x100.
- Wrap: redirect to 0xFFFF_FFFC, fetch it -> next request at 0x0000_0000, trap_out stays 0.
- Async reset: assert mp_rst_in mid-cycle while in HOLD with stall_in=1 -> outputs go to reset values before the next clock edge, pc_out=BOOT_ADDR.
